// File: rtl/lsu_mem_stage.sv
// Load/store unit: byte-addressed requests to a word-addressed RAM, with read-modify-write and load extension.
// Optional macro LSU_MISALIGN_SPLIT_EN: split word-crossing accesses in two; otherwise misaligned accesses error.
`timescale 1ns/1ps

module lsu_mem_stage #(
    parameter int MEM_WORDS = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_mem_we,
    output logic [31:0] o_mem_waddr,
    output logic [31:0] o_mem_wdata,
    output logic [31:0] o_mem_raddr,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [31:0] LP_MEM_WORDS = 32'(MEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_WR0,
        S_WR1,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_off;
    logic [31:0] r_w0;
    logic [31:0] r_w1;
    logic        r_cross;
    logic        r_err;
    logic [31:0] r_wdata;
    logic [31:0] r_buf0;
    logic [31:0] r_buf1;
    logic [31:0] r_waddr_hold;
    logic [31:0] r_wdata_hold;

    logic [1:0]  w_acc_off;
    logic [31:0] w_acc_w0;
    logic [31:0] w_acc_w1;
    logic        w_acc_cross;
    logic        w_acc_split;
    logic        w_acc_misalign;
    logic        w_acc_err;
    logic        w_acc_aligned_word;

    logic [7:0]  w_lane_mask;
    logic [63:0] w_lane_data;
    logic [31:0] w_merge0;
    logic [31:0] w_merge1;
    logic [31:0] w_load_raw;
    logic [31:0] w_load_ext;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    size_mask = 4'b0001;
            2'd1:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    always_comb begin
        w_acc_off   = i_req_addr[1:0];
        w_acc_w0    = {2'b00, i_req_addr[31:2]};
        w_acc_w1    = w_acc_w0 + 32'd1;
        w_acc_cross = 1'b0;
        case (i_req_size)
            2'd0:    w_acc_cross = 1'b0;
            2'd1:    w_acc_cross = (w_acc_off == 2'd3);
            default: w_acc_cross = (w_acc_off != 2'd0);
        endcase
`ifdef LSU_MISALIGN_SPLIT_EN
        w_acc_split    = w_acc_cross;
        w_acc_misalign = 1'b0;
`else
        // A misaligned word always crosses; a halfword at an odd lane is misaligned without crossing.
        w_acc_split    = 1'b0;
        w_acc_misalign = w_acc_cross || ((i_req_size == 2'd1) && w_acc_off[0]);
`endif
        w_acc_err = (i_req_size == 2'd3)
                 || (w_acc_w0 >= LP_MEM_WORDS)
                 || (w_acc_split && (w_acc_w1 >= LP_MEM_WORDS))
                 || w_acc_misalign;
        w_acc_aligned_word = i_req_we && (i_req_size == 2'd2) && (w_acc_off == 2'd0);
    end

    // Store bytes are laid across an 8-lane window spanning w0 (lanes 0-3) and w1 (lanes 4-7).
    always_comb begin
        w_lane_mask = {4'b0000, size_mask(r_size)} << r_off;
        w_lane_data = {32'd0, r_wdata} << {r_off, 3'b000};
        w_merge0    = r_buf0;
        w_merge1    = r_buf1;
        for (int i = 0; i < 4; i++) begin
            w_merge0[8*i +: 8] = w_lane_mask[i]   ? w_lane_data[8*i +: 8]     : r_buf0[8*i +: 8];
            w_merge1[8*i +: 8] = w_lane_mask[i+4] ? w_lane_data[8*(i+4) +: 8] : r_buf1[8*i +: 8];
        end
    end

    always_comb begin
        w_load_raw = 32'({r_buf1, r_buf0} >> {r_off, 3'b000});
        case (r_size)
            2'd0:    w_load_ext = r_unsigned ? {24'd0, w_load_raw[7:0]}
                                             : {{24{w_load_raw[7]}}, w_load_raw[7:0]};
            2'd1:    w_load_ext = r_unsigned ? {16'd0, w_load_raw[15:0]}
                                             : {{16{w_load_raw[15]}}, w_load_raw[15:0]};
            default: w_load_ext = w_load_raw;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        o_req_ready  = 1'b0;
        o_resp_valid = 1'b0;
        o_resp_err   = 1'b0;
        o_resp_rdata = 32'd0;
        o_mem_we     = 1'b0;
        o_mem_raddr  = 32'd0;
        o_mem_waddr  = r_waddr_hold;
        o_mem_wdata  = r_wdata_hold;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    if (w_acc_err)               w_next_state = S_RESP;
                    else if (w_acc_aligned_word) w_next_state = S_WR0;
                    else                         w_next_state = S_RD0;
                end
            end
            S_RD0: begin
                o_mem_raddr = r_w0;
                if (r_cross)   w_next_state = S_RD1;
                else if (r_we) w_next_state = S_WR0;
                else           w_next_state = S_RESP;
            end
            S_RD1: begin
                o_mem_raddr  = r_w1;
                w_next_state = r_we ? S_WR0 : S_RESP;
            end
            S_WR0: begin
                o_mem_we     = 1'b1;
                o_mem_waddr  = r_w0;
                o_mem_wdata  = w_merge0;
                w_next_state = r_cross ? S_WR1 : S_RESP;
            end
            S_WR1: begin
                o_mem_we     = 1'b1;
                o_mem_waddr  = r_w1;
                o_mem_wdata  = w_merge1;
                w_next_state = S_RESP;
            end
            S_RESP: begin
                o_resp_valid = 1'b1;
                o_resp_err   = r_err;
                if (!r_err && !r_we) o_resp_rdata = w_load_ext;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_size       <= 2'd0;
            r_unsigned   <= 1'b0;
            r_off        <= 2'd0;
            r_w0         <= 32'd0;
            r_w1         <= 32'd0;
            r_cross      <= 1'b0;
            r_err        <= 1'b0;
            r_wdata      <= 32'd0;
            r_buf0       <= 32'd0;
            r_buf1       <= 32'd0;
            r_waddr_hold <= 32'd0;
            r_wdata_hold <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_IDLE) && i_req_valid) begin
                r_we       <= i_req_we;
                r_size     <= i_req_size;
                r_unsigned <= i_req_unsigned;
                r_off      <= w_acc_off;
                r_w0       <= w_acc_w0;
                r_w1       <= w_acc_w1;
                r_cross    <= w_acc_split;
                r_err      <= w_acc_err;
                r_wdata    <= i_req_wdata;
            end
            if (r_state == S_RD0) r_buf0 <= i_mem_rdata;
            if (r_state == S_RD1) r_buf1 <= i_mem_rdata;
            // Write port holds its last address/data between write states.
            if (o_mem_we) begin
                r_waddr_hold <= o_mem_waddr;
                r_wdata_hold <= o_mem_wdata;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a behavioural RAM and a response scoreboard.
// Expectations follow LSU_MISALIGN_SPLIT_EN when it is defined for the build.
`timescale 1ns/1ps

module tb_lsu_mem_stage;

    localparam int MEM_WORDS = 4096;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rstN;
    logic        reqValid;
    logic        reqReady;
    logic        reqWe;
    logic [1:0]  reqSize;
    logic        reqUnsigned;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic        respValid;
    logic [31:0] respRdata;
    logic        respErr;
    logic        memWe;
    logic [31:0] memWaddr;
    logic [31:0] memWdata;
    logic [31:0] memRaddr;
    logic [31:0] memRdata;

    logic [31:0] ram [0:MEM_WORDS-1];
    int          checks = 0;
    int          errors = 0;
    int          cycleCnt = 0;
    bit          weSeen = 1'b0;
    exp_t        expQ[$];
    int          acceptQ[$];
    int          acceptLog[$];
    int          writeLog[$];
    exp_t        monExp;
    int          monAcc;

    lsu_mem_stage #(.MEM_WORDS(MEM_WORDS)) dut (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_req_valid    (reqValid),
        .o_req_ready    (reqReady),
        .i_req_we       (reqWe),
        .i_req_size     (reqSize),
        .i_req_unsigned (reqUnsigned),
        .i_req_addr     (reqAddr),
        .i_req_wdata    (reqWdata),
        .o_resp_valid   (respValid),
        .o_resp_rdata   (respRdata),
        .o_resp_err     (respErr),
        .o_mem_we       (memWe),
        .o_mem_waddr    (memWaddr),
        .o_mem_wdata    (memWdata),
        .o_mem_raddr    (memRaddr),
        .i_mem_rdata    (memRdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign memRdata = (memRaddr < 32'(MEM_WORDS)) ? ram[memRaddr[11:0]] : 32'h0;

    // RAM write port plus accept/write cycle logging.
    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
        if (rstN && reqValid && reqReady) begin
            acceptQ.push_back(cycleCnt);
            acceptLog.push_back(cycleCnt);
        end
        if (memWe) begin
            weSeen = 1'b1;
            writeLog.push_back(cycleCnt);
            if (memWaddr < 32'(MEM_WORDS)) ram[memWaddr[11:0]] = memWdata;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
        checks++;
        assert (obs === expVal) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, expVal);
        end
    endtask

    always @(negedge clk) begin
        if (rstN && respValid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_resp", {31'd0, respValid}, 32'd0);
            end else begin
                monExp = expQ.pop_front();
                monAcc = -1000;
                if (acceptQ.size() != 0) monAcc = acceptQ.pop_front();
                checkOutput("resp_rdata", respRdata, monExp.rdata);
                checkOutput("resp_err", {31'd0, respErr}, {31'd0, monExp.err});
                checkOutput("resp_latency", 32'(cycleCnt - monAcc), 32'(monExp.lat));
            end
        end
    end

    task automatic waitResp();
        int waited = 0;
        while (expQ.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("resp_pending", 32'(expQ.size()), 32'd0);
        expQ.delete();
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdataExp, input logic errExp, input int latExp);
        exp_t e;
        int waited = 0;
        e.rdata = rdataExp;
        e.err   = errExp;
        e.lat   = latExp;
        expQ.push_back(e);
        @(negedge clk);
        reqWe = we; reqSize = size; reqUnsigned = uns; reqAddr = addr; reqWdata = wdata;
        reqValid = 1'b1;
        while (!reqReady && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("req_ready_wait", {31'd0, reqReady}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        waitResp();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int aStart;
        int wStart;
        int waited;
        for (int i = 0; i < MEM_WORDS; i++) ram[i] = 32'h0;
        rstN = 1'b1; reqValid = 1'b0; reqWe = 1'b0; reqSize = 2'd0; reqUnsigned = 1'b0;
        reqAddr = 32'h0; reqWdata = 32'h0;
        #2 rstN = 1'b0;
        #10;
        checkOutput("rst_req_ready", {31'd0, reqReady}, 32'd1);
        checkOutput("rst_resp_valid", {31'd0, respValid}, 32'd0);
        checkOutput("rst_resp_err", {31'd0, respErr}, 32'd0);
        checkOutput("rst_resp_rdata", respRdata, 32'd0);
        checkOutput("rst_mem_we", {31'd0, memWe}, 32'd0);
        checkOutput("rst_mem_waddr", memWaddr, 32'd0);
        checkOutput("rst_mem_wdata", memWdata, 32'd0);
        checkOutput("rst_mem_raddr", memRaddr, 32'd0);
        @(negedge clk);
        rstN = 1'b1;

        ram[2] = 32'h11223344;
        ram[1] = 32'h000056F8;
        ram[3] = 32'h0;
        ram[MEM_WORDS-1] = 32'h80000000;

        $display("[TB] sub-word store and extended loads");
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h9, 32'h000000AB, 32'h0, 1'b0, 3);
        checkOutput("ram2_after_sb", ram[2], 32'h1122AB44);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h4, 32'h0, 32'hFFFFFFF8, 1'b0, 2);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h4, 32'h0, 32'h000000F8, 1'b0, 2);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h5, 32'h0, 32'h00000056, 1'b0, 2);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h4, 32'h0, 32'h000056F8, 1'b0, 2);
        applyStimulus(1'b0, 2'd1, 1'b1, 32'h8, 32'h0, 32'h0000AB44, 1'b0, 2);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h8, 32'h0, 32'hFFFFAB44, 1'b0, 2);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'h1122AB44, 1'b0, 2);

        $display("[TB] word and halfword stores");
        applyStimulus(1'b1, 2'd2, 1'b0, 32'hC, 32'hCAFEF00D, 32'h0, 1'b0, 2);
        checkOutput("ram3_after_sw", ram[3], 32'hCAFEF00D);
        applyStimulus(1'b1, 2'd1, 1'b0, 32'hE, 32'h00005566, 32'h0, 1'b0, 3);
        checkOutput("ram3_after_sh", ram[3], 32'h5566F00D);

        $display("[TB] crossing load");
        ram[0] = 32'hDDCCBBAA;
        ram[1] = 32'h44332211;
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, SPLIT ? 32'h2211DDCC : 32'h0, !SPLIT, SPLIT ? 3 : 1);

        $display("[TB] error cases and top-of-memory boundary");
        weSeen = 1'b0;
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h4000, 32'h12345678, 32'h0, 1'b1, 1);
        checkOutput("oob_no_write", {31'd0, weSeen}, 32'd0);
        applyStimulus(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h3FFF, 32'h0, 32'hFFFFFF80, 1'b0, 2);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h3FFC, 32'h0, 32'h80000000, 1'b0, 2);
        weSeen = 1'b0;
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h3FFE, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
        checkOutput("cross_oob_no_write", {31'd0, weSeen}, 32'd0);

        $display("[TB] crossing halfword store");
        applyStimulus(1'b1, 2'd1, 1'b0, 32'h7, 32'h0000BEEF, 32'h0, !SPLIT, SPLIT ? 5 : 1);
        checkOutput("ram1_after_cross", ram[1], SPLIT ? 32'hEF332211 : 32'h44332211);
        checkOutput("ram2_after_cross", ram[2], SPLIT ? 32'h1122ABBE : 32'h1122AB44);

        $display("[TB] reset during a write state");
        @(negedge clk);
        reqWe = 1'b1; reqSize = 2'd1; reqUnsigned = 1'b0; reqAddr = 32'h7; reqWdata = 32'h00001234;
`ifndef LSU_MISALIGN_SPLIT_EN
        reqSize = 2'd0; reqAddr = 32'h9; reqWdata = 32'h00000077;
`endif
        reqValid = 1'b1;
        checkOutput("abort_ready", {31'd0, reqReady}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
        repeat (3) @(negedge clk);
`else
        @(negedge clk);
`endif
        checkOutput("abort_we_before", {31'd0, memWe}, 32'd1);
        checkOutput("abort_waddr", memWaddr, 32'd2);
        rstN = 1'b0;
        #1;
        checkOutput("abort_we_dropped", {31'd0, memWe}, 32'd0);
        checkOutput("abort_ready_after", {31'd0, reqReady}, 32'd1);
        checkOutput("abort_no_resp", {31'd0, respValid}, 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        acceptQ.delete();
`ifdef LSU_MISALIGN_SPLIT_EN
        checkOutput("abort_ram1", ram[1], 32'h34332211);
        checkOutput("abort_ram2", ram[2], 32'h1122ABBE);
`else
        checkOutput("abort_ram2", ram[2], 32'h1122AB44);
`endif

        $display("[TB] back-to-back aligned word stores");
        expQ.push_back('{32'h0, 1'b0, 2});
        expQ.push_back('{32'h0, 1'b0, 2});
        aStart = acceptLog.size();
        wStart = writeLog.size();
        @(negedge clk);
        reqWe = 1'b1; reqSize = 2'd2; reqUnsigned = 1'b0; reqAddr = 32'h10; reqWdata = 32'hA5A50001;
        reqValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqAddr = 32'h14; reqWdata = 32'h5A5A0002;
        waited = 0;
        while (acceptLog.size() < aStart + 2 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        reqValid = 1'b0;
        checkOutput("b2b_accept_count", 32'(acceptLog.size() - aStart), 32'd2);
        waitResp();
        checkOutput("b2b_write_count", 32'(writeLog.size() - wStart), 32'd2);
        if (acceptLog.size() >= aStart + 2 && writeLog.size() >= wStart + 2) begin
            checkOutput("b2b_spacing", 32'(acceptLog[aStart+1] - acceptLog[aStart]), 32'd3);
            checkOutput("b2b_write0_cycle", 32'(writeLog[wStart]), 32'(acceptLog[aStart] + 1));
            checkOutput("b2b_write1_cycle", 32'(writeLog[wStart+1]), 32'(acceptLog[aStart+1] + 1));
        end
        checkOutput("b2b_ram4", ram[4], 32'hA5A50001);
        checkOutput("b2b_ram5", ram[5], 32'h5A5A0002);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
